// File: rtl/addsub_seq.sv
// Multi-byte sequential add/sub: one shared 8-bit slice, LSB byte first.
// Define ADDSUB_SEQ_OVF_EN to build signed-overflow detection; otherwise ovf is 0.
module addsub_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] s,
    output logic                co,
    output logic                ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            sub_r;
    logic [IW-1:0]   idx;
    logic            c;
    logic [W-1:0]    work;

    logic [7:0]      a_byte;
    logic [7:0]      b_eff;
    logic [8:0]      sum;
    logic [W-1:0]    work_nx;

    // Single shared 8-bit slice; the last byte is merged into the result combinationally.
    always_comb begin
        a_byte  = a_r[8*idx +: 8];
        b_eff   = sub_r ? ~b_r[8*idx +: 8] : b_r[8*idx +: 8];
        sum     = {1'b0, a_byte} + {1'b0, b_eff} + {8'b0, c};
        work_nx = work;
        work_nx[8*idx +: 8] = sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            sub_r <= 1'b0;
            idx   <= '0;
            c     <= 1'b0;
            work  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        a_r   <= a;
                        b_r   <= b;
                        sub_r <= sub;
                        idx   <= '0;
                        c     <= sub;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work <= work_nx;
                    c    <= sum[8];
                    if (idx == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        s     <= work_nx;
                        co    <= sub_r ^ sum[8];
`ifdef ADDSUB_SEQ_OVF_EN
                        ovf   <= (a_r[W-1] == b_eff[7]) && (sum[7] != a_r[W-1]);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef ADDSUB_SEQ_OVF_EN
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq (NBYTES=4): directed vectors, decoupled monitor.
module tb_addsub_seq;

`ifdef ADDSUB_SEQ_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] s;
    logic        co;
    logic        ovf;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    addsub_seq #(.NBYTES(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sub  (sub),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .s    (s),
        .co   (co),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals completion.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            chk("busy_with_done", {31'b0, busy}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
            end else begin
                e = sb.pop_front();
                chk("s", s, e.s);
                chk("co", {31'b0, co}, {31'b0, e.co});
                chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
            end
        end
    end

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         input logic [31:0] es, input logic eco, input logic eovf);
        a     = ia;
        b     = ib;
        sub   = isub;
        start = 1'b1;
        sb.push_back('{s: es, co: eco, ovf: eovf});
    endtask

    // Issues one op from IDLE and checks busy/done timing cycle by cycle.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                          input logic [31:0] es, input logic eco, input logic eovf);
        issue(ia, ib, isub, es, eco, eovf);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("busy_run", {31'b0, busy}, 32'd1);
            chk("done_early", {31'b0, done}, 32'd0);
            @(posedge clk); #1;
        end
        chk("done_lat", {31'b0, done}, 32'd1);
        chk("busy_end", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("done_pulse", {31'b0, done}, 32'd0);
    endtask

    initial begin
        int d0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_s", s, 32'd0);
        chk("rst_co", {31'b0, co}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, OVF_ON);
        run_op(32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0);
        run_op(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b0, OVF_ON);

        // start during RUN must be ignored
        d0 = done_cnt;
        issue(32'h01020304, 32'h10203040, 1'b0, 32'h11223344, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 32'hDEADBEEF;
        b = 32'h01010101;
        sub = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("ignored_start_dones", done_cnt - d0, 32'd1);

        // reset in 3rd RUN cycle aborts the op
        d0 = done_cnt;
        a = 32'h11111111;
        b = 32'h22222222;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_s", s, 32'd0);
        chk("abort_co", {31'b0, co}, 32'd0);
        chk("abort_ovf", {31'b0, ovf}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 32'd0);
        run_op(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);

        // back-to-back with start held high
        issue(32'h00000001, 32'h00000001, 1'b1, 32'h00000000, 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(posedge clk);
            #1;
            chk("b2b_done", {31'b0, done}, 32'd1);
            unique case (i)
                0: issue(32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
                1: issue(32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
                2: issue(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, OVF_ON);
                default: start = 1'b0;
            endcase
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
